button_events: RTL and testbench
================================

# button_events

Converts the debounced push-button level from the debouncer into one-cycle event strobes: press, release, single click, double click, long press and auto-repeat while held. It sits directly downstream of the debouncer, in the same clock domain, and feeds the UI/menu FSMs. Those FSMs never look at raw button levels.

## Interface
Parameters:
- `LONG_CYCLES`, default 12_500_000: hold time, in cycles after the press strobe, that qualifies a long press.
- `REPEAT_CYCLES`, default 2_500_000: interval between `repeat` strobes once long press is reached.
- `DCLICK_CYCLES`, default 7_500_000: window after a short release in which a second press counts as a double click.
- `CW`, default 24: counter width. It must hold max(`LONG_CYCLES`, `REPEAT_CYCLES`, `DCLICK_CYCLES`).

Ports:
- `clock`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset (asserted at 0).
- `clean`, input, 1: debounced button level, synchronous to `clock`, 1 = pressed.
- `press`, output, 1: one-cycle strobe on every press.
- `release`, output, 1: one-cycle strobe on every release.
- `single_click`, output, 1: one-cycle strobe for a short press with no second press inside the window.
- `double_click`, output, 1: one-cycle strobe on the second press of a double click.
- `long_press`, output, 1: one-cycle strobe when a hold reaches `LONG_CYCLES`.
- `repeat`, output, 1: one-cycle strobe every `REPEAT_CYCLES` while held past long press.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- Rising and falling edges are detected with a registered copy `level_q` of `clean`.
  - `level_q` resets to 0, so a button held through reset produces `press` after reset.
- A single counter `cnt` [CW-1:0] is cleared on every state entry and increments by 1 each cycle the FSM stays in a counting state.
- States and transitions:
  - **IDLE**
    - rise → PRESSED, `press`.
  - **PRESSED**
    - fall → WAIT2, `release`.
    - hold reaching `LONG_CYCLES` → HELD, `long_press`.
  - **HELD**
    - fall → IDLE, `release`.
    - otherwise `repeat` every `REPEAT_CYCLES`, with `cnt` wrapping to 0 on each `repeat`.
  - **WAIT2**
    - rise → PRESSED2, `press` and `double_click` together.
    - window expiry (`DCLICK_CYCLES`) → IDLE, `single_click`.
  - **PRESSED2**
    - fall → IDLE, `release`.
    - No long press and no repeat from this state.
- Outputs are all registered and are never high for more than one consecutive cycle.
- Simultaneous events:
  - A fall on the cycle the long threshold is reached: release wins, no `long_press`, go to WAIT2.
  - A rise on the cycle the window expires: double click wins, no `single_click`.
- `single_click` and `double_click` are mutually exclusive for a given click sequence.

## Timing
- Reset value of every output and of `busy` is 0.
  - State resets to IDLE; `cnt` and `level_q` reset to 0.
- Reset is honoured mid-operation at any state; no strobe is emitted on reset exit unless `clean` is 1.
- Let cycle P be the cycle `press` is high. `press` is high in the cycle after the first clock edge that samples `clean`=1 while `level_q`=0.
- `release` has the same 1-cycle latency from the first edge that samples `clean`=0.
- With the button held continuously:
  - `long_press` at P+`LONG_CYCLES`.
  - `repeat` at P+`LONG_CYCLES`+k·`REPEAT_CYCLES`, for k ≥ 1.
- Let R be the `release` cycle out of PRESSED.
  - With no further press, `single_click` is high at R+`DCLICK_CYCLES`.
  - A press whose strobe would land at or before R+`DCLICK_CYCLES` yields `double_click`.
- `busy` goes high with `press` and goes low in the cycle after the final strobe (`release` from HELD or PRESSED2, or `single_click`).

## Test plan
Bench parameters: `LONG_CYCLES`=8, `REPEAT_CYCLES`=4, `DCLICK_CYCLES`=6.

- **Short click:** `clean` high 3 cycles then low, idle 10 cycles → `press` at P, `release` at P+3, `single_click` at P+9; no other strobes; `busy` low at P+10.
- **Double click:** `clean` high 2 cycles, low 3, high 2, low → `press` twice; `double_click` on the second `press`; two `release` strobes; no `single_click`.
- **Long and repeat:** `clean` high 20 cycles → `long_press` at P+8, `repeat` at P+12, P+16; `release` 1 cycle after the fall; no `single_click`.
- **Threshold collision:** `clean` falls on the edge where `cnt` would reach 8 → `release` only, no `long_press`, then `single_click` 6 cycles later.
- **Reset mid-hold:** assert `reset`=0 while in HELD with `clean`=1 → all outputs 0 immediately. Release `reset` with `clean` still 1 → `press` 1 cycle later, new long press 8 cycles after that.
- **Window collision:** second press strobe lands exactly at R+6 → `double_click` asserted, `single_click` never asserted.

Source files
------------

// File: rtl/button_events.sv
// Turns the debounced button level into one-cycle event strobes for the UI/menu FSMs.
// A single counter times the long-press, repeat and double-click windows, and is cleared on every state entry.
module button_events #(
  parameter int LONG_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000,
  parameter int DCLICK_CYCLES = 7_500_000,
  parameter int CW            = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic clean,
  output logic press,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  // Each strobe is registered, so it appears one cycle after the edge that decides it.
  // The counter therefore compares against threshold-1.
  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_TC = CW'(DCLICK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRESSED, HELD, WAIT2, PRESSED2} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_q;
  logic          rise, fall;
  logic          press_nx, release_nx, single_nx, double_nx, long_nx, repeat_nx, busy_nx;

  assign rise = clean & ~level_q;
  assign fall = ~clean & level_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      level_q       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      level_q       <= clean;
      press         <= press_nx;
      release_pulse <= release_nx;
      single_click  <= single_nx;
      double_click  <= double_nx;
      long_press    <= long_nx;
      repeat_pulse  <= repeat_nx;
      busy          <= busy_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    single_nx  = 1'b0;
    double_nx  = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        // The edge is tested first so a release on the threshold cycle suppresses long_press.
        if (fall) begin
          state_nx   = WAIT2;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_nx = HELD;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else if (cnt == REPEAT_TC) begin
          cnt_nx    = '0;
          repeat_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT2: begin
        // A second press on the expiry cycle still counts as a double click.
        if (rise) begin
          state_nx  = PRESSED2;
          cnt_nx    = '0;
          press_nx  = 1'b1;
          double_nx = 1'b1;
        end else if (cnt == DCLICK_TC) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          single_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Busy stays high through the final strobe cycle and drops one cycle later.
    busy_nx = (state_nx != IDLE) | single_nx | release_nx;
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: stimulus pushes expected strobe events into a queue,
// and a monitor pops and compares them whenever any strobe is high.
module tb_button_events;

  localparam logic [5:0] EV_P  = 6'b100000;
  localparam logic [5:0] EV_R  = 6'b010000;
  localparam logic [5:0] EV_S  = 6'b001000;
  localparam logic [5:0] EV_D  = 6'b000100;
  localparam logic [5:0] EV_L  = 6'b000010;
  localparam logic [5:0] EV_RP = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] ev;
  } exp_t;

  logic clock, reset, clean;
  logic press, release_pulse, single_click, double_click, long_press, repeat_pulse, busy;

  int   cyc;
  int   passed;
  int   total;
  exp_t sb[$];

  button_events #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .DCLICK_CYCLES(6),
    .CW           (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clean        (clean),
    .press        (press),
    .release_pulse(release_pulse),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  function automatic logic [5:0] strobes();
    return {press, release_pulse, single_click, double_click, long_press, repeat_pulse};
  endfunction

  task automatic expect_ev(input int c, input logic [5:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [5:0] act, input logic [5:0] req);
    total = total + 1;
    if (act === req) passed = passed + 1;
    else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
  endtask

  // Monitor: any strobe activity must match the oldest queued expectation.
  initial begin
    exp_t e;
    logic [5:0] v;
    forever begin
      @(negedge clock);
      v = strobes();
      if (reset === 1'b1 && v !== 6'b0) begin
        total = total + 1;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_strobe at cycle %0d: got %b, expected none", cyc, v);
        end else begin
          e = sb.pop_front();
          if (e.cyc == cyc && e.ev === v) passed = passed + 1;
          else $display("FAIL strobe at cycle %0d: got %b, expected %b at cycle %0d",
                        cyc, v, e.ev, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    clean = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  initial begin
    int c;
    int d;
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    clean  = 1'b0;
    repeat (3) @(negedge clock);
    check_val("reset_strobes", strobes(), 6'b0);
    check_val("reset_busy", {5'b0, busy}, 6'b0);
    reset = 1'b1;
    drive(1'b0, 3);

    // Short click
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 4, EV_R);
    expect_ev(c + 10, EV_S);
    drive(1'b1, 3);
    clean = 1'b0;
    wait_to(c + 1);
    wait_to(c + 2);
    check_val("busy_click_held", {5'b0, busy}, 6'd1);
    wait_to(c + 10);
    check_val("busy_at_single", {5'b0, busy}, 6'd1);
    wait_to(c + 11);
    check_val("busy_after_single", {5'b0, busy}, 6'd0);
    drive(1'b0, 4);

    // Double click
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 3, EV_R);
    expect_ev(c + 6, EV_P | EV_D);
    expect_ev(c + 8, EV_R);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 2);
    clean = 1'b0;
    wait_to(c + 8);
    check_val("busy_dbl_last", {5'b0, busy}, 6'd1);
    wait_to(c + 9);
    check_val("busy_dbl_done", {5'b0, busy}, 6'd0);
    drive(1'b0, 12);

    // Long press and repeat
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 9, EV_L);
    expect_ev(c + 13, EV_RP);
    expect_ev(c + 17, EV_RP);
    expect_ev(c + 21, EV_R);
    drive(1'b1, 20);
    clean = 1'b0;
    wait_to(c + 22);
    check_val("busy_after_held", {5'b0, busy}, 6'd0);
    drive(1'b0, 10);

    // Release on the long-press threshold cycle
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 9, EV_R);
    expect_ev(c + 15, EV_S);
    drive(1'b1, 8);
    drive(1'b0, 14);

    // Reset while held
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 9, EV_L);
    clean = 1'b1;
    wait_to(c + 11);
    reset = 1'b0;
    #1;
    check_val("rst_mid_strobes", strobes(), 6'b0);
    check_val("rst_mid_busy", {5'b0, busy}, 6'd0);
    check_val("rst_mid_queue", 6'(sb.size()), 6'd0);
    @(negedge clock);
    @(negedge clock);
    d = cyc;
    expect_ev(d + 1, EV_P);
    expect_ev(d + 9, EV_L);
    expect_ev(d + 11, EV_R);
    reset = 1'b1;
    drive(1'b1, 10);
    drive(1'b0, 10);

    // Second press landing exactly as the window expires
    c = cyc;
    expect_ev(c + 1, EV_P);
    expect_ev(c + 3, EV_R);
    expect_ev(c + 9, EV_P | EV_D);
    expect_ev(c + 11, EV_R);
    drive(1'b1, 2);
    drive(1'b0, 6);
    drive(1'b1, 2);
    drive(1'b0, 15);

    check_val("queue_drained", 6'(sb.size()), 6'd0);
    check_val("final_busy", {5'b0, busy}, 6'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
